axi_master_pattern: RTL
=======================

AXI_MASTER_PATTERN -- requirements
Module: axi_master_pattern

Interface
REQ-001 Parameter WR_ID_VAL, default 2'd1: ID driven on WR_ID.
REQ-002 Parameter RD_ID_VAL, default 4'd2: ID driven on RD_ID and expected on RD_BACK_ID.
REQ-003 Ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- CMD_START  in  1  command request; sampled only in IDLE.
- CMD_WRITE  in  1  1 = write burst, 0 = read burst.
- CMD_ADDR  in  32  burst start address.
- CMD_LEN  in  8  beats minus one.
- CMD_SEED  in  32  pattern seed.
- RD_STALL  in  1  forces RD_DATA_READY low (backpressure test).
- BUSY  out  1  transaction in progress.
- DONE  out  1  one-cycle completion pulse.
- ERR_CNT  out  16  mismatch count, saturating.
- WR_ADDR/WR_LEN/WR_ID/WR_ADDR_VALID  out  32/8/2/1  write address channel.
- WR_ADDR_READY  in  1.
- WR_DATA/WR_STRB/WR_DATA_VALID/WR_DATA_LAST  out  32/4/1/1  write data channel.
- WR_DATA_READY  in  1.
- WR_BACK_ID  in  2  slave-returned write ID.
- RD_ADDR/RD_LEN/RD_ID/RD_ADDR_VALID  out  32/8/4/1  read address channel.
- RD_ADDR_READY  in  1.
- RD_DATA/RD_DATA_LAST/RD_BACK_ID/RD_DATA_VALID  in  32/1/4/1  read data channel.
- RD_DATA_READY  out  1.

Function
REQ-004 States: IDLE, WADDR, WDATA, RADDR, RDATA, FIN.
REQ-005 IDLE with CMD_START=1: on that edge, latch CMD_ADDR, CMD_LEN, CMD_SEED, and CMD_WRITE; clear ERR_CNT to 0; clear beat counter k to 0; go to WADDR if write, else RADDR.
REQ-006 CMD_START outside IDLE is ignored; latched command fields are held stable until FIN.
REQ-007 WADDR/RADDR: the matching *_ADDR_VALID is 1 with latched ADDR/LEN/ID; VALID stays high until the cycle VALID&READY=1; the state then moves to WDATA/RDATA on that edge.
REQ-008 The data phase never overlaps the address phase; the first data VALID appears no earlier than 1 cycle after the address handshake.
REQ-009 WDATA: WR_DATA_VALID=1 continuously; WR_DATA=seed+k (mod 2^32); WR_STRB=4'hF; WR_DATA_LAST=1 iff k==LEN.
REQ-010 WDATA: k increments on each WR_DATA_VALID&WR_DATA_READY; handshake at k==LEN goes to FIN.
REQ-011 On every write-data handshake with WR_BACK_ID!=WR_ID_VAL, ERR_CNT increments by 1.
REQ-012 RDATA: RD_DATA_READY = ~RD_STALL; a beat is accepted when RD_DATA_VALID&RD_DATA_READY.
REQ-013 Per accepted read beat, ERR_CNT increments by 1 if any of these holds: RD_DATA!=seed+k, RD_BACK_ID!=RD_ID_VAL, or RD_DATA_LAST!=(k==LEN); multiple faults in one beat count as 1.
REQ-014 The read burst ends on the accepted beat with k==LEN regardless of RD_DATA_LAST; an early LAST is counted as an error and does not terminate the burst.
REQ-015 FIN: DONE=1 for exactly one cycle; then IDLE. BUSY=1 in every state except IDLE.
REQ-016 ERR_CNT saturates at 16'hFFFF; it holds its value after DONE until the next accepted CMD_START.
REQ-017 CMD_LEN=0 gives single-beat bursts; LEN=255 gives 256 beats, and k does not wrap before completion.
REQ-018 Outside their own states, all channel VALIDs, WR_DATA_LAST, and RD_DATA_READY are 0; WR_ADDR/RD_ADDR/LEN/ID/WR_DATA hold their last values.

Reset
REQ-019 On a clock edge with rst=1: state=IDLE; k=0; ERR_CNT=0; BUSY=0; DONE=0; all *_VALID=0; RD_DATA_READY=0; WR_DATA_LAST=0; WR_STRB=0; all addr/len/id/data outputs=0.
REQ-020 rst asserted mid-burst drops all VALIDs on that edge; no completion, DONE, or error increment is produced for the aborted burst.

Verification
REQ-021 Write, ADDR=0x1000, LEN=3, SEED=0xA0, slave always ready with correct ID -> data 0xA0..0xA3, LAST on the 4th beat only, DONE pulse, ERR_CNT=0.
REQ-022 Read, LEN=7, SEED=0, slave returns 0..7 with LAST on beat 7 and RD_STALL toggling every cycle -> 8 beats accepted only while ready, ERR_CNT=0.
REQ-023 Read, LEN=3, beat 2 data corrupted and LAST asserted on beat 1 -> ERR_CNT=2, completion after 4th beat.
REQ-024 Write with WR_ADDR_READY delayed 5 cycles -> WR_ADDR_VALID high 6 cycles with stable address; a CMD_START pulse during the burst is ignored.
REQ-025 rst for 1 cycle during WDATA beat 2 of LEN=7 -> all outputs at reset values next cycle, BUSY=0, no DONE.
REQ-026 Read with RD_BACK_ID=4'hF on all 256 beats of LEN=255 -> ERR_CNT=256, DONE once.

Source files
------------

// File: rtl/axi_master_pattern.sv
// axi_master_pattern
//   Single-burst AXI-style traffic generator and checker. A command captured
//   in IDLE issues one write or read burst. Write beats carry the pattern
//   seed+k; read beats are checked against the same pattern, and mismatches
//   are counted in a saturating 16-bit error counter.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   CMD_START/WRITE/ADDR/LEN/SEED   command request (sampled in IDLE only)
//   RD_STALL                 forces RD_DATA_READY low
//   BUSY, DONE, ERR_CNT      status: in progress, 1-cycle done pulse, error count
//   WR_ADDR/LEN/ID/ADDR_VALID, WR_ADDR_READY      write address channel
//   WR_DATA/STRB/DATA_VALID/DATA_LAST, WR_DATA_READY, WR_BACK_ID  write data
//   RD_ADDR/LEN/ID/ADDR_VALID, RD_ADDR_READY      read address channel
//   RD_DATA/DATA_LAST/BACK_ID/DATA_VALID, RD_DATA_READY           read data
module axi_master_pattern #(
    parameter logic [1:0] WR_ID_VAL = 2'd1,
    parameter logic [3:0] RD_ID_VAL = 4'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CMD_START,
    input  logic        CMD_WRITE,
    input  logic [31:0] CMD_ADDR,
    input  logic [7:0]  CMD_LEN,
    input  logic [31:0] CMD_SEED,
    input  logic        RD_STALL,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] ERR_CNT,
    output logic [31:0] WR_ADDR,
    output logic [7:0]  WR_LEN,
    output logic [1:0]  WR_ID,
    output logic        WR_ADDR_VALID,
    input  logic        WR_ADDR_READY,
    output logic [31:0] WR_DATA,
    output logic [3:0]  WR_STRB,
    output logic        WR_DATA_VALID,
    output logic        WR_DATA_LAST,
    input  logic        WR_DATA_READY,
    input  logic [1:0]  WR_BACK_ID,
    output logic [31:0] RD_ADDR,
    output logic [7:0]  RD_LEN,
    output logic [3:0]  RD_ID,
    output logic        RD_ADDR_VALID,
    input  logic        RD_ADDR_READY,
    input  logic [31:0] RD_DATA,
    input  logic        RD_DATA_LAST,
    input  logic [3:0]  RD_BACK_ID,
    input  logic        RD_DATA_VALID,
    output logic        RD_DATA_READY
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [7:0]  k_q, k_d;
    logic [7:0]  len_q, len_d;
    logic [31:0] seed_q, seed_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_len_q, wr_len_d;
    logic [1:0]  wr_id_q, wr_id_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [7:0]  rd_len_q, rd_len_d;
    logic [3:0]  rd_id_q, rd_id_d;

    logic [31:0] beat_data;
    logic        last_beat;
    logic        rd_fault;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign beat_data = seed_q + {24'd0, k_q};
    assign last_beat = (k_q == len_q);
    // Any number of faults in one read beat counts as a single error.
    assign rd_fault  = (RD_DATA != beat_data) || (RD_BACK_ID != RD_ID_VAL) ||
                       (RD_DATA_LAST != last_beat);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        len_d     = len_q;
        seed_d    = seed_q;
        err_cnt_d = err_cnt_q;
        wr_addr_d = wr_addr_q;
        wr_len_d  = wr_len_q;
        wr_id_d   = wr_id_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        rd_len_d  = rd_len_q;
        rd_id_d   = rd_id_q;
        case (state_q)
            S_IDLE: begin
                if (CMD_START) begin
                    seed_d    = CMD_SEED;
                    len_d     = CMD_LEN;
                    k_d       = 8'd0;
                    err_cnt_d = 16'd0;
                    if (CMD_WRITE) begin
                        wr_addr_d = CMD_ADDR;
                        wr_len_d  = CMD_LEN;
                        wr_id_d   = WR_ID_VAL;
                        state_d   = S_WADDR;
                    end else begin
                        rd_addr_d = CMD_ADDR;
                        rd_len_d  = CMD_LEN;
                        rd_id_d   = RD_ID_VAL;
                        state_d   = S_RADDR;
                    end
                end
            end
            S_WADDR: if (WR_ADDR_READY) state_d = S_WDATA;
            S_WDATA: begin
                if (WR_DATA_READY) begin
                    // Remember the beat so WR_DATA holds it after the burst.
                    wr_data_d = beat_data;
                    if (WR_BACK_ID != WR_ID_VAL) err_cnt_d = sat_inc(err_cnt_q);
                    // k stops at LEN so a 256-beat burst never wraps it.
                    if (last_beat) state_d = S_FIN;
                    else           k_d     = k_q + 8'd1;
                end
            end
            S_RADDR: if (RD_ADDR_READY) state_d = S_RDATA;
            S_RDATA: begin
                if (RD_DATA_VALID && !RD_STALL) begin
                    if (rd_fault) err_cnt_d = sat_inc(err_cnt_q);
                    // Completion is by beat count; an early RD_DATA_LAST is only an error.
                    if (last_beat) state_d = S_FIN;
                    else           k_d     = k_q + 8'd1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= 8'd0;
            len_q     <= 8'd0;
            seed_q    <= 32'd0;
            err_cnt_q <= 16'd0;
            wr_addr_q <= 32'd0;
            wr_len_q  <= 8'd0;
            wr_id_q   <= 2'd0;
            wr_data_q <= 32'd0;
            rd_addr_q <= 32'd0;
            rd_len_q  <= 8'd0;
            rd_id_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            len_q     <= len_d;
            seed_q    <= seed_d;
            err_cnt_q <= err_cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_len_q  <= wr_len_d;
            wr_id_q   <= wr_id_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            rd_len_q  <= rd_len_d;
            rd_id_q   <= rd_id_d;
        end
    end

    assign BUSY          = (state_q != S_IDLE);
    assign DONE          = (state_q == S_FIN);
    assign ERR_CNT       = err_cnt_q;
    assign WR_ADDR       = wr_addr_q;
    assign WR_LEN        = wr_len_q;
    assign WR_ID         = wr_id_q;
    assign WR_ADDR_VALID = (state_q == S_WADDR);
    assign WR_DATA_VALID = (state_q == S_WDATA);
    assign WR_DATA       = (state_q == S_WDATA) ? beat_data : wr_data_q;
    assign WR_STRB       = (state_q == S_WDATA) ? 4'hF : 4'h0;
    assign WR_DATA_LAST  = (state_q == S_WDATA) && last_beat;
    assign RD_ADDR       = rd_addr_q;
    assign RD_LEN        = rd_len_q;
    assign RD_ID         = rd_id_q;
    assign RD_ADDR_VALID = (state_q == S_RADDR);
    assign RD_DATA_READY = (state_q == S_RDATA) && !RD_STALL;

endmodule
